unit_conv_seq: RTL and testbench
================================

Name: unit_conv_seq

Overview:
- Parametrised successor to the fixed 5x5 convolution unit.
- Holds several weight sets in an internal weight memory and buffers a raster-scanned IFM channel in a sliding-window line buffer.
- Computes each KxK dot product with one time-multiplexed signed fixed-point MAC.
- Streams IFM in and OFM out over valid/ready handshakes. Sits between the RISC-V loader/IFM source and the accumulation stage.

Parameters:
- DATA_WIDTH, 16: signed fixed-point width of weights, pixels and results.
- FRAC_BITS, 8: fractional bits of all DATA_WIDTH values.
- IFM_SIZE, 5: IFM width and height (square).
- KERNAL_SIZE, 3: kernel width and height; 1 <= KERNAL_SIZE <= IFM_SIZE.
- NUMBER_OF_FILTERS, 4: number of weight sets stored.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(KERNAL_SIZE*KERNAL_SIZE)+1: accumulator width.
- ADDRESS_SIZE_WM, $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS): weight address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- wm_enable_write  in  1  weight write strobe.
- wm_address  in  ADDRESS_SIZE_WM  weight write address: filter*K*K + r*K + c.
- riscv_data  in  DATA_WIDTH  weight write data.
- filter_sel  in  max(1,$clog2(NUMBER_OF_FILTERS))  weight set for the next run; latched on start.
- start  in  1  begin one IFM pass.
- ifm_valid  in  1  pixel valid.
- ifm_ready  out  1  unit accepts a pixel.
- unit_data_in  in  DATA_WIDTH  IFM pixel, raster order.
- ofm_valid  out  1  result valid.
- ofm_ready  in  1  downstream accepts the result.
- unit_data_out  out  DATA_WIDTH  OFM result.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; row/col/tap counters=0; accumulator=0; ifm_ready=0, ofm_valid=0, unit_data_out=0, busy=0, done=0. Weight memory and line buffer are not cleared. Reset mid-pass abandons the pass; no partial output.
- Weight writes are accepted only in IDLE. A write while busy is ignored. An out-of-range address (>= K*K*NUMBER_OF_FILTERS) is ignored.
- Geometry: stride 1, no padding. OFM is (IFM_SIZE-K+1)^2 results in raster order.
- IDLE: on start=1, latch filter_sel, clear row/col, go to FILL. start while busy is ignored.
- FILL: ifm_ready=1. On each ifm_valid&&ifm_ready, shift the pixel into the line buffer (depth (K-1)*IFM_SIZE+K) and advance col, then row.
  - If the accepted pixel has row>=K-1 and col>=K-1: go to MAC.
  - Otherwise stay in FILL.
- MAC: ifm_ready=0. Clear the accumulator on the first cycle, then run K*K cycles, tap t=0..K*K-1 in raster order: acc += W[filter][t] * window[t], sign-extended to ACC_WIDTH.
- OUT: ofm_valid=1 and unit_data_out=sat(acc >>> FRAC_BITS).
  - Shift is arithmetic (floor).
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - unit_data_out is held stable while ofm_ready=0; ifm_ready=0 throughout.
  - On ofm_valid&&ofm_ready: if the last triggering pixel was (IFM_SIZE-1, IFM_SIZE-1), go to DONE; otherwise go to FILL.
- DONE: done=1 for one cycle, then IDLE.
- Latency: ofm_valid rises exactly K*K+1 cycles after the clock edge that accepted the triggering pixel.
- Gaps in ifm_valid stall FILL only. Pixels offered outside FILL are not consumed.
- K=1: a single MAC cycle per pixel; every pixel triggers.

Test Plan:
- K=3, IFM=5: write all 9 weights of filter 0 = 0x0100 (1.0); stream 25 pixels = 0x0100 -> 9 outputs, each 0x0900; done pulses once after the 9th handshake.
- Filter 1 = identity (centre tap 0x0100, rest 0); pixels p(r,c)=(r*5+c)<<8; filter_sel=1 -> outputs 0x0600,0x0700,0x0800,0x0B00,...,0x1200.
- Saturation: all weights 0x7FFF, pixels 0x7FFF -> every output 0x7FFF; weights 0x8000, pixels 0x7FFF -> 0x8000.
- Backpressure/latency: ofm_ready=0 for 10 cycles on the first result -> ofm_valid rises 10 cycles after the 13th pixel handshake; data stable; ifm_ready=0 until the handshake. Random ifm_valid gaps -> identical output sequence.
- Reset asserted during MAC of the 3rd output -> all outputs 0 immediately; after release, a new start without reloading weights gives a full, correct 9-output pass.
- Weight write with busy=1, and start during FILL -> both ignored; results match the pre-write weights.

Source files
------------

// File: rtl/unit_conv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : unit_conv_seq
//  Description : KxK sliding-window convolution over a raster-scanned IFM
//                channel using one time-multiplexed signed fixed-point MAC.
//  Revision    : 1.0
// ============================================================================
module unit_conv_seq #(
    parameter int DATA_WIDTH        = 16,
    parameter int FRAC_BITS         = 8,
    parameter int IFM_SIZE          = 5,
    parameter int KERNAL_SIZE       = 3,
    parameter int NUMBER_OF_FILTERS = 4,
    parameter int ACC_WIDTH         = 2*DATA_WIDTH + $clog2(KERNAL_SIZE*KERNAL_SIZE) + 1,
    parameter int ADDRESS_SIZE_WM   = $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wm_enable_write,
    input  logic [ADDRESS_SIZE_WM-1:0] wm_address,
    input  logic [DATA_WIDTH-1:0]      riscv_data,
    input  logic [((NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1)-1:0] filter_sel,
    input  logic                       start,
    input  logic                       ifm_valid,
    output logic                       ifm_ready,
    input  logic [DATA_WIDTH-1:0]      unit_data_in,
    output logic                       ofm_valid,
    input  logic                       ofm_ready,
    output logic [DATA_WIDTH-1:0]      unit_data_out,
    output logic                       busy,
    output logic                       done
);

    localparam int c_FSEL_W     = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
    localparam int c_KK         = KERNAL_SIZE * KERNAL_SIZE;
    localparam int c_WM_DEPTH   = c_KK * NUMBER_OF_FILTERS;
    localparam int c_LB_DEPTH   = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE;
    localparam int c_POS_W      = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) + 1 : 1;
    localparam int c_STEP_W     = $clog2(c_KK + 1);
    localparam int c_TAP_W      = (c_KK > 1) ? $clog2(c_KK) : 1;
    localparam int c_PROD_W     = 2 * DATA_WIDTH;
    localparam int c_WM_LIMIT_W = ADDRESS_SIZE_WM + 1;

    localparam logic [c_POS_W-1:0]      c_LAST_POS  = c_POS_W'(IFM_SIZE - 1);
    localparam logic [c_POS_W-1:0]      c_TRIG_POS  = c_POS_W'(KERNAL_SIZE - 1);
    localparam logic [c_STEP_W-1:0]     c_LAST_STEP = c_STEP_W'(c_KK);
    localparam logic [c_WM_LIMIT_W-1:0] c_WM_LIMIT  = c_WM_LIMIT_W'(c_WM_DEPTH);
    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_MAC  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [c_POS_W-1:0]            r_row;
    logic [c_POS_W-1:0]            r_col;
    logic [c_STEP_W-1:0]           r_step;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [c_FSEL_W-1:0]           r_filter;
    logic                          r_last;

    logic [DATA_WIDTH-1:0]         r_wmem [c_WM_DEPTH];
    logic [DATA_WIDTH-1:0]         r_lb   [c_LB_DEPTH];
    logic [DATA_WIDTH-1:0]         w_window [c_KK];

    logic                          w_pix_fire;
    logic                          w_trigger;
    logic                          w_at_end;
    logic [c_TAP_W-1:0]            w_tap;
    logic [ADDRESS_SIZE_WM-1:0]    w_rd_addr;
    logic [DATA_WIDTH-1:0]         w_weight;
    logic [DATA_WIDTH-1:0]         w_pixel;
    logic signed [c_PROD_W-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_shift;
    logic [DATA_WIDTH-1:0]         w_sat;

    assign w_pix_fire = (r_state == S_FILL) && ifm_valid;
    assign w_trigger  = (r_row >= c_TRIG_POS) && (r_col >= c_TRIG_POS);
    assign w_at_end   = (r_row == c_LAST_POS) && (r_col == c_LAST_POS);

    // Newest pixel sits at r_lb[0]; tap (r,c) lies (K-1-r) rows and (K-1-c) pixels back.
    for (genvar gr = 0; gr < KERNAL_SIZE; gr++) begin : g_win_row
        for (genvar gc = 0; gc < KERNAL_SIZE; gc++) begin : g_win_col
            assign w_window[gr*KERNAL_SIZE + gc] =
                r_lb[(KERNAL_SIZE-1-gr)*IFM_SIZE + (KERNAL_SIZE-1-gc)];
        end
    end

    // Step 0 clears the accumulator, steps 1..K*K consume taps 0..K*K-1.
    assign w_tap      = c_TAP_W'(r_step - c_STEP_W'(1));
    assign w_rd_addr  = ADDRESS_SIZE_WM'(int'(r_filter) * c_KK + int'(w_tap));
    assign w_weight   = r_wmem[w_rd_addr];
    assign w_pixel    = w_window[w_tap];
    assign w_prod     = $signed(w_weight) * $signed(w_pixel);
    assign w_prod_ext = {{(ACC_WIDTH-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    assign w_shift    = r_acc >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[DATA_WIDTH-1:0];
        if (w_shift > c_SAT_MAX) begin
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shift < c_SAT_MIN) begin
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_FILL;
            S_FILL: if (w_pix_fire && w_trigger) w_state_next = S_MAC;
            S_MAC:  if (r_step == c_LAST_STEP) w_state_next = S_OUT;
            S_OUT:  if (ofm_ready) w_state_next = r_last ? S_DONE : S_FILL;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_step   <= '0;
            r_acc    <= '0;
            r_filter <= '0;
            r_last   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_filter <= filter_sel;
                        r_row    <= '0;
                        r_col    <= '0;
                    end
                end
                S_FILL: begin
                    if (w_pix_fire) begin
                        r_last <= w_at_end;
                        r_step <= '0;
                        if (r_col == c_LAST_POS) begin
                            r_col <= '0;
                            r_row <= r_row + c_POS_W'(1);
                        end else begin
                            r_col <= r_col + c_POS_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    r_step <= r_step + c_STEP_W'(1);
                    if (r_step == '0) begin
                        r_acc <= '0;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    // Weight store and line buffer keep their contents across reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && wm_enable_write && ({1'b0, wm_address} < c_WM_LIMIT)) begin
            r_wmem[wm_address] <= riscv_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pix_fire) begin
            r_lb[0] <= unit_data_in;
            for (int i = 1; i < c_LB_DEPTH; i++) begin
                r_lb[i] <= r_lb[i-1];
            end
        end
    end

    assign ifm_ready     = (r_state == S_FILL);
    assign ofm_valid     = (r_state == S_OUT);
    assign unit_data_out = (r_state == S_OUT) ? w_sat : '0;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_unit_conv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unit_conv_seq
//  Description : Directed self-checking bench for unit_conv_seq (K=3, IFM=5).
//  Revision    : 1.0
// ============================================================================
module tb_unit_conv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        wm_enable_write;
    logic [5:0]  wm_address;
    logic [15:0] riscv_data;
    logic [1:0]  filter_sel;
    logic        start;
    logic        ifm_valid;
    logic        ifm_ready;
    logic [15:0] unit_data_in;
    logic        ofm_valid;
    logic        ofm_ready;
    logic [15:0] unit_data_out;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    unit_conv_seq dut (
        .clk             (clk),
        .reset           (reset),
        .wm_enable_write (wm_enable_write),
        .wm_address      (wm_address),
        .riscv_data      (riscv_data),
        .filter_sel      (filter_sel),
        .start           (start),
        .ifm_valid       (ifm_valid),
        .ifm_ready       (ifm_ready),
        .unit_data_in    (unit_data_in),
        .ofm_valid       (ofm_valid),
        .ofm_ready       (ofm_ready),
        .unit_data_out   (unit_data_out),
        .busy            (busy),
        .done            (done)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] pix [25];
    logic [15:0] outq [$];
    logic [15:0] exp_id [9] = '{16'h0600, 16'h0700, 16'h0800,
                                16'h0B00, 16'h0C00, 16'h0D00,
                                16'h1000, 16'h1100, 16'h1200};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
        $fatal(1);
    end

    task automatic write_weight(input int addr, input logic [15:0] val);
        wm_enable_write = 1'b1;
        wm_address      = 6'(addr);
        riscv_data      = val;
        @(posedge clk); #1;
        wm_enable_write = 1'b0;
    endtask

    task automatic load_filter(input int f, input logic [15:0] val, input bit identity);
        for (int t = 0; t < 9; t++) begin
            write_weight(f*9 + t, (!identity || t == 4) ? val : 16'h0000);
        end
    endtask

    task automatic start_pass(input logic [1:0] sel);
        filter_sel = sel;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Drives one IFM pass and collects handshaken results into outq.
    task automatic run_pass(input bit gaps, input int hold_first, input int inject_cyc,
                            input int abort_pix, input int max_cycles,
                            output int n_done, output int t_trig, output int t_first,
                            output int hold_bad);
        int pi, vcnt, extra, post;
        logic [15:0] held;
        bit have_held;
        pi = 0; vcnt = 0; extra = 0; post = 0; held = '0; have_held = 0;
        n_done = 0; t_trig = -1; t_first = -1; hold_bad = 0;
        outq.delete();
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            ifm_valid    = (pi < 25) && (!gaps || ($urandom_range(0, 3) != 0));
            unit_data_in = pix[(pi < 25) ? pi : 24];
            ofm_ready    = !(hold_first > 0 && outq.size() == 0 && vcnt < hold_first);
            if (cyc == inject_cyc) begin
                wm_enable_write = 1'b1;
                wm_address      = 6'd0;
                riscv_data      = 16'h7FFF;
                start           = 1'b1;
                filter_sel      = 2'd1;
            end else begin
                wm_enable_write = 1'b0;
                start           = 1'b0;
            end
            @(negedge clk);
            if (ifm_valid && ifm_ready) begin
                if (pi == 12) t_trig = cyc;
                pi++;
            end
            if (ofm_valid && t_first < 0) t_first = cyc;
            if (ofm_valid && !ofm_ready) begin
                vcnt++;
                if (!have_held) begin
                    held      = unit_data_out;
                    have_held = 1;
                end else if (unit_data_out !== held) begin
                    hold_bad++;
                end
                if (ifm_ready !== 1'b0) hold_bad++;
            end
            if (ofm_valid && ofm_ready) outq.push_back(unit_data_out);
            if (done) n_done++;
            @(posedge clk); #1;
            if (n_done > 0) begin
                post++;
                if (post >= 3) break;
            end
            if (abort_pix > 0 && pi >= abort_pix) begin
                extra++;
                if (extra >= 3) break;
            end
        end
        ifm_valid       = 1'b0;
        wm_enable_write = 1'b0;
        start           = 1'b0;
        ofm_ready       = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        tests_run++;
        if ({ifm_ready, ofm_valid, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 0000", {ifm_ready, ofm_valid, busy, done});
        end
        tests_run++;
        if (unit_data_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, expected 0000", unit_data_out);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy got %b, expected 0", busy);
        end
    endtask

    task automatic test_ones();
        int nd, tt, tf, hb;
        logic [15:0] got;
        load_filter(0, 16'h0100, 0);
        for (int i = 0; i < 25; i++) pix[i] = 16'h0100;
        start_pass(2'd0);
        run_pass(0, 0, -1, 0, 600, nd, tt, tf, hb);
        tests_run++;
        if (outq.size() != 9) begin
            tests_failed++;
            $display("FAIL ones_count: got %0d, expected 9", outq.size());
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < outq.size()) ? outq[i] : 16'hxxxx;
            tests_run++;
            if (got !== 16'h0900) begin
                tests_failed++;
                $display("FAIL ones_out[%0d]: got %h, expected 0900", i, got);
            end
        end
        tests_run++;
        if (nd != 1) begin
            tests_failed++;
            $display("FAIL ones_done: got %0d pulses, expected 1", nd);
        end
    endtask

    task automatic test_identity();
        int nd, tt, tf, hb;
        logic [15:0] got;
        load_filter(1, 16'h0100, 1);
        for (int i = 0; i < 25; i++) pix[i] = 16'(i * 256);
        start_pass(2'd1);
        run_pass(0, 0, -1, 0, 600, nd, tt, tf, hb);
        for (int i = 0; i < 9; i++) begin
            got = (i < outq.size()) ? outq[i] : 16'hxxxx;
            tests_run++;
            if (got !== exp_id[i]) begin
                tests_failed++;
                $display("FAIL identity_out[%0d]: got %h, expected %h", i, got, exp_id[i]);
            end
        end
        tests_run++;
        if (nd != 1) begin
            tests_failed++;
            $display("FAIL identity_done: got %0d pulses, expected 1", nd);
        end
    endtask

    task automatic test_saturation();
        int nd, tt, tf, hb;
        logic [15:0] got;
        logic [15:0] wv [2] = '{16'h7FFF, 16'h8000};
        logic [15:0] ev [2] = '{16'h7FFF, 16'h8000};
        for (int s = 0; s < 2; s++) begin
            load_filter(2 + s, wv[s], 0);
            for (int i = 0; i < 25; i++) pix[i] = 16'h7FFF;
            start_pass(2'(2 + s));
            run_pass(0, 0, -1, 0, 600, nd, tt, tf, hb);
            tests_run++;
            if (outq.size() != 9) begin
                tests_failed++;
                $display("FAIL sat%0d_count: got %0d, expected 9", s, outq.size());
            end
            for (int i = 0; i < 9; i++) begin
                got = (i < outq.size()) ? outq[i] : 16'hxxxx;
                tests_run++;
                if (got !== ev[s]) begin
                    tests_failed++;
                    $display("FAIL sat%0d_out[%0d]: got %h, expected %h", s, i, got, ev[s]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nd, tt, tf, hb;
        logic [15:0] got;
        for (int i = 0; i < 25; i++) pix[i] = 16'(i * 256);
        start_pass(2'd1);
        run_pass(1, 10, -1, 0, 1500, nd, tt, tf, hb);
        // Rise happens 10 edges after the accepting edge; first negedge sample is one cycle on.
        tests_run++;
        if (tt < 0 || tf - tt != 11) begin
            tests_failed++;
            $display("FAIL bp_latency: got trig=%0d first_valid=%0d, expected first_valid=trig+11", tt, tf);
        end
        tests_run++;
        if (hb != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d unstable/ready cycles, expected 0", hb);
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < outq.size()) ? outq[i] : 16'hxxxx;
            tests_run++;
            if (got !== exp_id[i]) begin
                tests_failed++;
                $display("FAIL bp_out[%0d]: got %h, expected %h", i, got, exp_id[i]);
            end
        end
        tests_run++;
        if (nd != 1) begin
            tests_failed++;
            $display("FAIL bp_done: got %0d pulses, expected 1", nd);
        end
    endtask

    task automatic test_reset_mid_pass();
        int nd, tt, tf, hb;
        logic [15:0] got;
        for (int i = 0; i < 25; i++) pix[i] = 16'h0100;
        start_pass(2'd0);
        run_pass(0, 0, -1, 15, 600, nd, tt, tf, hb);
        tests_run++;
        if ({busy, ifm_ready, ofm_valid} !== 3'b100 || outq.size() != 2) begin
            tests_failed++;
            $display("FAIL rst_mac_point: got busy/ifm_ready/ofm_valid=%b outs=%0d, expected 100 outs=2",
                     {busy, ifm_ready, ofm_valid}, outq.size());
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({ifm_ready, ofm_valid, busy, done} !== 4'b0000 || unit_data_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_async: got flags=%b data=%h, expected 0000 0000",
                     {ifm_ready, ofm_valid, busy, done}, unit_data_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_pass(2'd0);
        run_pass(0, 0, -1, 0, 600, nd, tt, tf, hb);
        tests_run++;
        if (outq.size() != 9) begin
            tests_failed++;
            $display("FAIL rst_rerun_count: got %0d, expected 9", outq.size());
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < outq.size()) ? outq[i] : 16'hxxxx;
            tests_run++;
            if (got !== 16'h0900) begin
                tests_failed++;
                $display("FAIL rst_rerun_out[%0d]: got %h, expected 0900", i, got);
            end
        end
    endtask

    task automatic test_ignored_ops();
        int nd, tt, tf, hb;
        logic [15:0] got;
        for (int i = 0; i < 25; i++) pix[i] = 16'h0100;
        start_pass(2'd0);
        run_pass(0, 0, 3, 0, 600, nd, tt, tf, hb);
        for (int i = 0; i < 9; i++) begin
            got = (i < outq.size()) ? outq[i] : 16'hxxxx;
            tests_run++;
            if (got !== 16'h0900) begin
                tests_failed++;
                $display("FAIL ignore_out[%0d]: got %h, expected 0900", i, got);
            end
        end
        tests_run++;
        if (nd != 1) begin
            tests_failed++;
            $display("FAIL ignore_done: got %0d pulses, expected 1", nd);
        end
        // Re-run in a clean pass to confirm weight 0 of filter 0 was not overwritten.
        start_pass(2'd0);
        run_pass(0, 0, -1, 0, 600, nd, tt, tf, hb);
        got = (outq.size() > 0) ? outq[0] : 16'hxxxx;
        tests_run++;
        if (got !== 16'h0900) begin
            tests_failed++;
            $display("FAIL ignore_weight_kept: got %h, expected 0900", got);
        end
    endtask

    initial begin
        reset           = 1'b1;
        wm_enable_write = 1'b0;
        wm_address      = '0;
        riscv_data      = '0;
        filter_sel      = '0;
        start           = 1'b0;
        ifm_valid       = 1'b0;
        unit_data_in    = '0;
        ofm_ready       = 1'b1;
        test_reset();
        test_ones();
        test_identity();
        test_saturation();
        test_backpressure();
        test_reset_mid_pass();
        test_ignored_ops();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
